// File: rtl/br_param_bank_pkg.sv
// Shared types and default sizes for the br_param_bank register bank.
package br_param_bank_pkg;

    localparam int BR_WIDTH_DEF = 32;
    localparam int BR_DEPTH_DEF = 32;
    localparam int BR_NR_DEF    = 2;

    typedef enum logic {
        BR_IDLE  = 1'b0,
        BR_CLEAR = 1'b1
    } brState_t;

endpackage

// File: rtl/br_param_bank_clear_fsm.sv
// Clear sequencer: after reset or a clr request, walks idx 0..DEPTH-1 zeroing one register per cycle.
module br_clear_fsm
    import br_param_bank_pkg::*;
#(
    parameter  int DEPTH = BR_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          busy,
    output logic          clear_we,
    output logic [AW-1:0] clear_idx
);

    brState_t      state;
    logic [AW-1:0] idx;
    logic          busyReg;

    // clr is only honoured from IDLE; a reset mid-sequence restarts at idx 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= BR_CLEAR;
            idx     <= '0;
            busyReg <= 1'b1;
        end else begin
            case (state)
                BR_CLEAR: begin
                    if (idx == AW'(DEPTH - 1)) begin
                        state   <= BR_IDLE;
                        idx     <= '0;
                        busyReg <= 1'b0;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                BR_IDLE: begin
                    if (clr) begin
                        state   <= BR_CLEAR;
                        idx     <= '0;
                        busyReg <= 1'b1;
                    end
                end
                default: begin
                    state   <= BR_CLEAR;
                    idx     <= '0;
                    busyReg <= 1'b1;
                end
            endcase
        end
    end

    assign busy      = busyReg;
    assign clear_we  = busyReg;
    assign clear_idx = idx;

endmodule

// File: rtl/br_param_bank.sv
// DEPTH x WIDTH register bank, NR async read ports, two sync write ports (port 1 wins), hardware clear.
// Optional same-cycle write-to-read forwarding is enabled by defining BR_BYPASS_EN.
module br_param_bank
    import br_param_bank_pkg::*;
#(
    parameter  int WIDTH    = BR_WIDTH_DEF,
    parameter  int DEPTH    = BR_DEPTH_DEF,
    parameter  int NR       = BR_NR_DEF,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    output logic                busy,
    input  logic                RW0,
    input  logic [AW-1:0]       WR0,
    input  logic [WIDTH-1:0]    WD0,
    input  logic                RW1,
    input  logic [AW-1:0]       WR1,
    input  logic [WIDTH-1:0]    WD1,
    input  logic [NR*AW-1:0]    RR,
    output logic [NR*WIDTH-1:0] RD
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic             busyInt;
    logic             clearWe;
    logic [AW-1:0]    clearIdx;
    logic             wrOk0;
    logic             wrOk1;

    br_clear_fsm #(.DEPTH(DEPTH)) uClear (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .busy      (busyInt),
        .clear_we  (clearWe),
        .clear_idx (clearIdx)
    );

    assign busy  = busyInt;
    assign wrOk0 = RW0 && !((ZERO_REG != 0) && (WR0 == '0));
    assign wrOk1 = RW1 && !((ZERO_REG != 0) && (WR1 == '0));

    // Port 1 is assigned last so it overrides port 0 on an address collision.
    always_ff @(posedge clk) begin
        if (clearWe) begin
            regs[clearIdx] <= '0;
        end else if (rst_n) begin
            if (wrOk0) regs[WR0] <= WD0;
            if (wrOk1) regs[WR1] <= WD1;
        end
    end

    for (genvar k = 0; k < NR; k++) begin : gRead
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;

        assign addr = RR[k*AW +: AW];

        // Busy and the hard-wired zero register override everything, including forwarding.
        always_comb begin
            data = regs[addr];
`ifdef BR_BYPASS_EN
            if (RW1 && (WR1 == addr)) begin
                data = WD1;
            end else if (RW0 && (WR0 == addr)) begin
                data = WD0;
            end
`endif
            if (busyInt || ((ZERO_REG != 0) && (addr == '0))) begin
                data = '0;
            end
        end

        assign RD[k*WIDTH +: WIDTH] = data;
    end

endmodule

// File: tb/tb_br_param_bank.sv
// Self-checking bench for br_param_bank: table vectors, hand sequences and random traffic vs. an array model.
module tb_br_param_bank;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NR    = 2;
    localparam int AW    = $clog2(DEPTH);

    logic                clk = 1'b0;
    logic                rst_n;
    logic                clr;
    logic                busy;
    logic                RW0, RW1;
    logic [AW-1:0]       WR0, WR1;
    logic [WIDTH-1:0]    WD0, WD1;
    logic [NR*AW-1:0]    RR;
    logic [NR*WIDTH-1:0] RD;
    logic [AW-1:0]       rr [NR];

    logic [WIDTH-1:0] model [DEPTH];
    int               busyLeft;
    int               testsRun;
    int               testsFailed;

    typedef struct {
        bit               rw0;
        logic [AW-1:0]    wr0;
        logic [WIDTH-1:0] wd0;
        bit               rw1;
        logic [AW-1:0]    wr1;
        logic [WIDTH-1:0] wd1;
        logic [AW-1:0]    rd;
        logic [WIDTH-1:0] exp;
    } vec_t;

    vec_t vecs [7];

    assign RR = {rr[1], rr[0]};

    always #5 clk = ~clk;

    br_param_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NR(NR), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .busy  (busy),
        .RW0   (RW0),
        .WR0   (WR0),
        .WD0   (WD0),
        .RW1   (RW1),
        .WR1   (WR1),
        .WD1   (WD1),
        .RR    (RR),
        .RD    (RD)
    );

    function automatic logic [WIDTH-1:0] expRd(input logic [AW-1:0] a);
        if (busyLeft > 0) return '0;
        if (a == '0) return '0;
`ifdef BR_BYPASS_EN
        if (RW1 && WR1 == a) return WD1;
        if (RW0 && WR0 == a) return WD0;
`endif
        return model[a];
    endfunction

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        busyLeft = DEPTH;
    endtask

    task automatic modelEdge();
        if (!rst_n) begin
            clearModel();
        end else if (busyLeft > 0) begin
            busyLeft--;
        end else if (clr) begin
            clearModel();
        end else begin
            if (RW0 && WR0 != '0) model[WR0] = WD0;
            if (RW1 && WR1 != '0) model[WR1] = WD1;
        end
    endtask

    task automatic checkOutput(input string name);
        logic [WIDTH-1:0] e;
        logic             eb;
        eb = (busyLeft > 0);
        testsRun++;
        if (busy !== eb) begin
            testsFailed++;
            $display("[TB] FAIL %s busy got %b expected %b", name, busy, eb);
        end
        for (int k = 0; k < NR; k++) begin
            e = expRd(rr[k]);
            testsRun++;
            if (RD[k*WIDTH +: WIDTH] !== e) begin
                testsFailed++;
                $display("[TB] FAIL %s RD%0d addr %0d got %h expected %h",
                         name, k, rr[k], RD[k*WIDTH +: WIDTH], e);
            end
        end
    endtask

    task automatic checkConst(input string name, input int k, input logic [WIDTH-1:0] e);
        testsRun++;
        if (RD[k*WIDTH +: WIDTH] !== e) begin
            testsFailed++;
            $display("[TB] FAIL %s RD%0d got %h expected %h", name, k, RD[k*WIDTH +: WIDTH], e);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit c,
                                 input bit w0, input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                                 input bit w1, input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1,
                                 input logic [AW-1:0] q0, input logic [AW-1:0] q1);
        rst_n = r; clr = c;
        RW0 = w0; WR0 = a0; WD0 = d0;
        RW1 = w1; WR1 = a1; WD1 = d1;
        rr[0] = q0; rr[1] = q1;
    endtask

    task automatic step(input string name);
        @(negedge clk);
        checkOutput(name);
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    initial begin
        int busyCount;
        testsRun = 0;
        testsFailed = 0;
        clearModel();

        vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0,      5'd5,  32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 5'd7,  32'h1,         1'b1, 5'd7,  32'h2,      5'd7,  32'h2};
        vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0,      5'd0,  32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  32'hA5A5,   5'd3,  32'hA5A5};
        vecs[4] = '{1'b1, 5'd12, 32'h1111,      1'b1, 5'd13, 32'h2222,   5'd12, 32'h1111};
        vecs[5] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,      5'd13, 32'h2222};
        vecs[6] = '{1'b1, 5'd31, 32'hCAFE,      1'b1, 5'd0,  32'h5555,   5'd31, 32'hCAFE};

        // Reset held for two edges, then the 32-cycle clear with RD forced to zero.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 5'd9);
        @(posedge clk);
        modelEdge();
        #1;
        step("reset");
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            rr[0] = AW'($urandom);
            rr[1] = AW'($urandom);
            step("initClear");
        end

        for (int v = 0; v < 7; v++) begin
            applyStimulus(1, 0, vecs[v].rw0, vecs[v].wr0, vecs[v].wd0,
                          vecs[v].rw1, vecs[v].wr1, vecs[v].wd1, vecs[v].rd, vecs[v].rd);
            step("vecWrite");
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, vecs[v].rd, vecs[v].rd);
            @(negedge clk);
            checkConst("vecRead", 0, vecs[v].exp);
            checkOutput("vecRead");
            @(posedge clk);
            modelEdge();
            #1;
        end

        // Same-cycle read of a register being written.
        applyStimulus(1, 0, 0, 0, 0, 1, 5'd9, 32'h1234, 5'd0, 5'd9);
        @(negedge clk);
`ifdef BR_BYPASS_EN
        checkConst("bypassSame", 1, 32'h1234);
`else
        checkConst("bypassSame", 1, 32'h0);
`endif
        @(posedge clk);
        modelEdge();
        #1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd9);
        @(negedge clk);
        checkConst("bypassNext", 1, 32'h1234);
        @(posedge clk);
        modelEdge();
        #1;

        // Fill, clr, reset at idx 10, count the restarted busy window with writes attempted.
        for (int i = 1; i < 5; i++) begin
            applyStimulus(1, 0, 1, AW'(i), WIDTH'(32'h100 + i), 0, 0, 0, AW'(i), 5'd9);
            step("fill");
        end
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 5'd1, 5'd2);
        step("clrReq");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, (i == 3), 1, 5'd20, $urandom, 0, 0, 0, 5'd1, 5'd20);
            step("clrRun");
        end
        applyStimulus(0, 0, 1, 5'd20, 32'hBAD0, 1, 5'd21, 32'hBAD1, 5'd20, 5'd21);
        step("midReset");
        rst_n = 1'b1;
        busyCount = 0;
        for (int i = 0; i < 4 * DEPTH; i++) begin
            @(negedge clk);
            checkOutput("restart");
            if (busy !== 1'b1) begin
                RW0 = 1'b0;
                RW1 = 1'b0;
                break;
            end
            busyCount++;
            @(posedge clk);
            modelEdge();
            #1;
        end
        @(posedge clk);
        modelEdge();
        #1;
        testsRun++;
        if (busyCount != DEPTH) begin
            testsFailed++;
            $display("[TB] FAIL busyCount got %0d expected %0d", busyCount, DEPTH);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 5'd20, 5'd21);
        @(negedge clk);
        checkConst("droppedWr", 0, 32'h0);
        checkConst("droppedWr", 1, 32'h0);
        @(posedge clk);
        modelEdge();
        #1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd4);
        step("clearedFill");

        // Random traffic against the model, with occasional clr and reset.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 249) != 0), ($urandom_range(0, 79) == 0),
                          $urandom_range(0, 1), AW'($urandom), $urandom,
                          $urandom_range(0, 1), AW'($urandom), $urandom,
                          AW'($urandom), AW'($urandom));
            if ($urandom_range(0, 3) == 0) rr[0] = WR0;
            if ($urandom_range(0, 3) == 0) rr[1] = WR1;
            step("random");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
